fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, is the sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-006 redirect_pc  input  32  redirect target; sampled when redirect_valid=1.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address; equals current PC.
REQ-009 imem_ack  input  1  memory read complete, one cycle, sampled only while imem_req=1.
REQ-010 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-011 if_valid  output  1  fetched instruction held for decode.
REQ-012 if_pc  output  32  PC of the held instruction.
REQ-013 if_instr  output  32  held instruction word.
REQ-014 id_ready  input  1  decode accepts; transfer when if_valid and id_ready are both 1.
REQ-015 fault  output  1  sticky misaligned-redirect error.
REQ-016 fetch_count  output  32  count of instructions accepted by decode; wraps at 2^32.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD, FAULT.
REQ-018 IDLE: imem_req=0; next state REQ.
REQ-019 REQ: imem_req=1, imem_addr=pc held stable; on imem_ack, capture imem_rdata into if_instr and pc into if_pc, next state HOLD; without imem_ack, remain in REQ.
REQ-020 HOLD: if_valid=1, imem_req=0; on id_ready, pc <= pc + PC_STEP (32-bit, wraps at 2^32), fetch_count increments, next state REQ; otherwise if_valid, if_pc and if_instr hold unchanged.
REQ-021 Redirect has priority over all other events in IDLE, REQ and HOLD: pc <= redirect_pc; if_valid drops the next cycle; next state IDLE.
REQ-022 An imem_ack coinciding with a redirect SHALL be discarded.
REQ-023 A HOLD transfer (id_ready=1) coinciding with a redirect SHALL still count in fetch_count; pc still takes redirect_pc.
REQ-024 A redirect with redirect_pc[1:0]!=0 SHALL set fault=1 and enter FAULT instead of IDLE.
REQ-025 FAULT: imem_req=0, if_valid=0; redirects ignored; exited only by rst.
REQ-026 Latency: with imem_ack returned in the request cycle, if_valid rises 2 cycles after entering IDLE; steady-state throughput is one instruction per 2 cycles.
REQ-027 The PC SHALL never change while imem_req=1 except through a redirect.

Reset
REQ-028 While rst=1 (synchronous; overrides redirect and ack): state=IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0, fault=0, fetch_count=0.
REQ-029 Reset asserted mid-REQ or mid-HOLD SHALL abandon the access; an ack arriving during reset is ignored.
REQ-030 The first request after reset deassertion SHALL be at cycle 2, with imem_addr=RESET_PC.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, the PC width (32) and the default PC_STEP and RESET_PC constants.
REQ-032 The PC increment SHALL use the codebase's existing adder block as the single sub-module instance; all other logic is inline.

Verification
REQ-033 Reset then constant imem_ack=1 and id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC on every second cycle; fetch_count=4 after the fourth accept.
REQ-034 imem_ack delayed 3 cycles -> imem_req=1 with imem_addr stable for 4 cycles; if_instr equals the data presented with the ack.
REQ-035 id_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr unchanged, no new request; accept on the 6th cycle -> next request at pc+4.
REQ-036 redirect_valid with redirect_pc=0x100 in the same cycle as imem_ack -> data discarded; imem_req=0 for one cycle; next imem_addr=0x100.
REQ-037 redirect_pc=0x102 -> fault=1 and imem_req=0 permanently; a later aligned redirect is ignored; rst clears fault and the next request is at RESET_PC.
REQ-038 rst asserted while in REQ with imem_ack=1 -> if_valid stays 0; the first request after deassertion is at 0x0 and fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_adder.sv
// Plain W-bit wrapping adder used for the sequential PC increment.
module fetch_sequencer_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem read per instruction, holds the
// word for decode, follows redirects and latches a sticky misaligned fault.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_instr,
  input  logic            id_ready,
  output logic            fault,
  output logic [PC_W-1:0] fetch_count,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic            imem_req_q;
  logic            if_valid_q;
  logic [PC_W-1:0] if_pc_q;
  logic [PC_W-1:0] if_instr_q;
  logic            fault_q;
  logic [PC_W-1:0] fetch_count_q;

  fetch_sequencer_adder #(.W(PC_W)) u_pc_adder (
    .a_i  (pc_q),
    .b_i  (PC_STEP),
    .sum_o(pc_inc)
  );

  // Handshakes: imem_ack is only honoured while imem_req=1 (state REQ); a
  // decode transfer happens on a cycle where if_valid=1 and id_ready=1, after
  // which if_valid drops until the next word arrives. Redirects outrank both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else if (state_q != ST_FAULT) begin
      // A transfer in the same cycle as a redirect was still consumed by decode.
      if (state_q == ST_HOLD && id_ready) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        imem_req_q <= 1'b0;
        if_valid_q <= 1'b0;
        if (pc_aligned(redirect_pc)) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_REQ;
            imem_req_q <= 1'b1;
          end
          ST_REQ: begin
            if (imem_ack) begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              imem_req_q <= 1'b0;
              state_q    <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (id_ready) begin
              pc_q       <= pc_inc;
              if_valid_q <= 1'b0;
              imem_req_q <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule
